jt7759_divmeas: RTL and testbench

- Reader side of the uPD7759 clock-enable divider.
- Watches the base 640 kHz cen together with the divider's cen_ctl/cen_dec strobes and recovers the divider setting (divby) and decoder sample period in cen ticks.
- Declares lock once the measurement is stable; flags loss of lock.
- Feeds the output sample-rate tag of the resampler and serves as a synthesizable monitor in the sound subsystem.

---
 rtl/jt7759_divmeas_pkg.sv | 21 ++
 rtl/jt7759_divmeas_cnt.sv | 59 +++++
 rtl/jt7759_divmeas.sv | 140 ++++++++++++++
 tb/tb_jt7759_divmeas.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jt7759_divmeas_pkg.sv
// rtl/jt7759_divmeas_pkg.sv - shared types and constants for the uPD7759 divider monitor
package jt7759_divmeas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int PW = 9;

    localparam logic [PW-1:0] PMIN        = 9'd4;
    localparam logic [PW-1:0] PMAX        = 9'd256;
    localparam logic [2:0]    CTL_PER_DEC = 3'd4;

    // A decoder interval is usable when it spans a whole number of divider periods
    function automatic logic period_ok(input logic [PW-1:0] p);
        return (p >= PMIN) && (p <= PMAX) && (p[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/jt7759_divmeas_cnt.sv
// rtl/jt7759_divmeas_cnt.sv - interval counters and capture (ctl counting under JT7759_DIVMEAS_CTLCHK_EN)
module jt7759_divmeas_cnt
    import jt7759_divmeas_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          cen_ctl,
    input  logic          cen_dec,
    output logic [PW-1:0] pcnt,
    output logic [PW-1:0] cap_period,
    output logic [2:0]    cap_ctl,
    output logic          cap_stb
);

    // Capture is combinational so the FSM can act on the cen_dec clk itself
    assign cap_period = pcnt;
    assign cap_stb    = cen_dec;

    // Cen ticks since the last cen_dec; a cen on the cen_dec clk starts the new interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (cen_dec) begin
            pcnt <= {{(PW-1){1'b0}}, cen};
        end else if (pcnt != {PW{1'b1}}) begin
            pcnt <= pcnt + {{(PW-1){1'b0}}, cen};
        end
    end

`ifdef JT7759_DIVMEAS_CTLCHK_EN
    logic [2:0] ccnt;
    logic [2:0] ccnt_inc;

    // Saturating increment shared by the capture and the counter update
    always_comb begin
        ccnt_inc = ccnt;
        if (cen_ctl && ccnt != 3'd7) ccnt_inc = ccnt + 3'd1;
    end

    assign cap_ctl = ccnt_inc;

    // Control strobes seen since the last cen_dec
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccnt <= '0;
        end else if (cen_dec) begin
            ccnt <= '0;
        end else begin
            ccnt <= ccnt_inc;
        end
    end
`else
    logic ctl_unused;
    assign ctl_unused = cen_ctl;
    assign cap_ctl    = CTL_PER_DEC;
`endif

endmodule

// File: rtl/jt7759_divmeas.sv
// rtl/jt7759_divmeas.sv - recovers divby/period from the uPD7759 divider strobes (option: JT7759_DIVMEAS_CTLCHK_EN)
module jt7759_divmeas
    import jt7759_divmeas_pkg::*;
#(
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = 320
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          cen_ctl,
    input  logic          cen_dec,
    output logic [PW-1:0] period,
    output logic [5:0]    divby,
    output logic          locked,
    output logic          chg,
    output logic          err
);

    localparam logic [2:0]    LOCK_V = 3'(LOCK_CNT);
    localparam logic [PW-1:0] TO_V   = PW'(TIMEOUT);

    logic [PW-1:0] pcnt;
    logic [PW-1:0] cap_period;
    logic [2:0]    cap_ctl;
    logic          cap_stb;

    jt7759_divmeas_cnt u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .cen_ctl    (cen_ctl),
        .cen_dec    (cen_dec),
        .pcnt       (pcnt),
        .cap_period (cap_period),
        .cap_ctl    (cap_ctl),
        .cap_stb    (cap_stb)
    );

    state_t        state;
    logic [2:0]    match;
    logic [PW-1:0] ref_p;

    logic          valid;
    logic          same;
    logic          timeout;
    logic [5:0]    divby_new;
    logic          div_unused;
    logic [2:0]    m_next;
    logic [PW-1:0] r_next;

`ifdef JT7759_DIVMEAS_CTLCHK_EN
    assign valid = period_ok(cap_period) && (cap_ctl == CTL_PER_DEC);
`else
    logic ctl_unused;
    assign ctl_unused = ^cap_ctl;
    assign valid      = period_ok(cap_period);
`endif

    assign same    = valid && (cap_period == ref_p);
    assign timeout = (pcnt >= TO_V);

    // period/4 - 1; the top bit is always zero for a valid period
    assign {div_unused, divby_new} = cap_period[PW-1:2] - 7'd1;

    // Acquisition bookkeeping for the interval ending on this cen_dec
    always_comb begin
        m_next = '0;
        r_next = ref_p;
        if (valid) begin
            if (cap_period == ref_p) begin
                m_next = (match == 3'd7) ? match : match + 3'd1;
            end else begin
                m_next = 3'd1;
                r_next = cap_period;
            end
        end
    end

    // Lock FSM with registered outputs; cen_dec takes priority over timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            match  <= '0;
            ref_p  <= '0;
            period <= '0;
            divby  <= '0;
            locked <= 1'b0;
            chg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            chg <= 1'b0;
            err <= 1'b0;
            if (cap_stb) period <= cap_period;
            case (state)
                IDLE: begin
                    if (cap_stb) begin
                        state <= ACQ;
                        match <= '0;
                    end
                end
                ACQ: begin
                    if (cap_stb) begin
                        match <= m_next;
                        ref_p <= r_next;
                        if (m_next >= LOCK_V) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            divby  <= divby_new;
                            chg    <= (divby_new != divby);
                        end
                    end else if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (cap_stb) begin
                        if (!same) begin
                            state  <= ACQ;
                            match  <= m_next;
                            ref_p  <= r_next;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end else if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt7759_divmeas.sv
// tb/tb_jt7759_divmeas.sv - directed bench for jt7759_divmeas
module tb_jt7759_divmeas;
    import jt7759_divmeas_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       cen_ctl = 1'b0;
    logic       cen_dec = 1'b0;
    logic [8:0] period;
    logic [5:0] divby;
    logic       locked;
    logic       chg;
    logic       err;

    int total = 0;
    int bad = 0;
    int chg_cnt = 0;
    int err_cnt = 0;
    logic pre_locked = 1'b0;
    logic post_locked = 1'b0;

    jt7759_divmeas dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .cen_ctl (cen_ctl),
        .cen_dec (cen_dec),
        .period  (period),
        .divby   (divby),
        .locked  (locked),
        .chg     (chg),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chg) chg_cnt++;
        if (err) err_cnt++;
    end

    typedef struct {
        int div;
        int exp_period;
        int exp_chg;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic ctl, input logic dec);
        @(posedge clk);
        #1;
        cen = c;
        cen_ctl = ctl;
        cen_dec = dec;
    endtask

    // One 640 kHz tick: cen, then the divider strobes one clk later, then two idle clks
    task automatic tick(input logic ctl, input logic dec);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, ctl, dec);
        if (dec) begin
            @(negedge clk);
            pre_locked = locked;
        end
        step(1'b0, 1'b0, 1'b0);
        if (dec) begin
            @(negedge clk);
            post_locked = locked;
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    // One decoder interval of the divider at setting div, with nctl control strobes
    task automatic interval(input int div, input int nctl, input logic dec_en);
        int k;
        int n;
        k = div + 1;
        n = 4 * k;
        for (int t = 1; t <= n; t++) begin
            tick((t % k == 0) && (t / k <= nctl), dec_en && (t == n));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cen = 1'b0;
        cen_ctl = 1'b0;
        cen_dec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chg_cnt = 0;
        err_cnt = 0;
    endtask

    initial begin
        vecs[0] = '{div: 5,  exp_period: 24,  exp_chg: 1};
        vecs[1] = '{div: 63, exp_period: 256, exp_chg: 1};
        vecs[2] = '{div: 0,  exp_period: 4,   exp_chg: 0};
        vecs[3] = '{div: 9,  exp_period: 40,  exp_chg: 1};
        vecs[4] = '{div: 1,  exp_period: 8,   exp_chg: 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({period, divby, locked, chg, err}), 0);
        do_reset();

        // Table: lock on the clk after the third cen_dec from reset
        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int j = 0; j < 3; j++) interval(vecs[i].div, 4, 1'b1);
            check($sformatf("v%0d_pre_lock", i), int'(pre_locked), 0);
            check($sformatf("v%0d_locked", i), int'(post_locked), 1);
            check($sformatf("v%0d_period", i), int'(period), vecs[i].exp_period);
            check($sformatf("v%0d_divby", i), int'(divby), vecs[i].div);
            check($sformatf("v%0d_chg", i), chg_cnt, vecs[i].exp_chg);
            check($sformatf("v%0d_err", i), err_cnt, 0);
        end

        // Divider changes from 5 to 9 while locked
        do_reset();
        for (int j = 0; j < 3; j++) interval(5, 4, 1'b1);
        chg_cnt = 0;
        err_cnt = 0;
        interval(9, 4, 1'b1);
        check("switch_err", err_cnt, 1);
        check("switch_unlock", int'(post_locked), 0);
        interval(9, 4, 1'b1);
        check("switch_relock", int'(post_locked), 1);
        check("switch_divby", int'(divby), 9);
        check("switch_period", int'(period), 40);
        check("switch_chg", chg_cnt, 1);

        // Timeout while locked, then resume
        interval(5, 4, 1'b1);
        interval(5, 4, 1'b1);
        check("to_prelock", int'(post_locked), 1);
        err_cnt = 0;
        for (int t = 0; t < 318; t++) tick(1'b0, 1'b0);
        check("to_still_locked", int'(locked), 1);
        for (int t = 0; t < 12; t++) tick(1'b0, 1'b0);
        check("to_unlocked", int'(locked), 0);
        check("to_err_once", err_cnt, 1);
        check("to_state_idle", int'(dut.state), int'(IDLE));
        check("to_divby_kept", int'(divby), 5);
        for (int j = 0; j < 3; j++) interval(5, 4, 1'b1);
        check("to_relock", int'(post_locked), 1);

        // Intervals of 26 ticks never lock
        err_cnt = 0;
        for (int j = 0; j < 4; j++) begin
            for (int t = 1; t <= 26; t++) tick(1'b0, t == 26);
        end
        check("odd_locked", int'(locked), 0);
        check("odd_err", err_cnt, 1);
        check("odd_period", int'(period), 26);
        check("odd_divby_kept", int'(divby), 5);

        // Asynchronous reset in the middle of an interval
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", int'({period, divby, locked, chg, err}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three control strobes per interval
        do_reset();
        for (int j = 0; j < 4; j++) interval(5, 3, 1'b1);
`ifdef JT7759_DIVMEAS_CTLCHK_EN
        check("ctl3_locked", int'(locked), 0);
        check("ctl3_divby", int'(divby), 0);
`else
        check("ctl3_locked", int'(locked), 1);
        check("ctl3_divby", int'(divby), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
